// File: rtl/reconstrutor_caminho.sv
// rtl/reconstrutor_caminho.sv - walks the predecessor memory from destination back to source and streams the path
module reconstrutor_caminho #(
    parameter int ADDR_WIDTH   = 10,
    parameter int MAX_PATH_LEN = 1024,
    parameter int CNT_WIDTH    = 11
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start_in,
    input  logic                  encontrado_in,
    input  logic [ADDR_WIDTH-1:0] fonte_in,
    input  logic [ADDR_WIDTH-1:0] destino_in,
    output logic                  pai_rd_en_out,
    output logic [ADDR_WIDTH-1:0] pai_addr_out,
    input  logic [ADDR_WIDTH-1:0] pai_data_in,
    output logic                  caminho_valid_out,
    input  logic                  caminho_ready_in,
    output logic [ADDR_WIDTH-1:0] caminho_addr_out,
    output logic                  caminho_last_out,
    output logic                  busy_out,
    output logic                  done_out,
    output logic [1:0]            erro_out,
    output logic [CNT_WIDTH-1:0]  num_nos_out
);

    typedef enum logic [2:0] {IDLE, EMIT, READ, WAIT, FIM} state_t;

    localparam logic [CNT_WIDTH-1:0] MAX_CNT = CNT_WIDTH'(MAX_PATH_LEN);

    localparam logic [1:0] ERR_OK        = 2'd0;
    localparam logic [1:0] ERR_NOT_FOUND = 2'd1;
    localparam logic [1:0] ERR_LOOP      = 2'd2;
    localparam logic [1:0] ERR_LENGTH    = 2'd3;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] fonte_q, fonte_d;
    logic [ADDR_WIDTH-1:0] current_q, current_d;
    logic [ADDR_WIDTH-1:0] pai_addr_q, pai_addr_d;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
    logic [CNT_WIDTH-1:0]  num_nos_q, num_nos_d;
    logic [1:0]            erro_q, erro_d;
    logic [CNT_WIDTH-1:0]  cnt_inc;
    logic                  is_last;

    // Reset is asynchronous and active-high on this codebase's rst_n.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state_q    <= IDLE;
            fonte_q    <= '0;
            current_q  <= '0;
            pai_addr_q <= '0;
            cnt_q      <= '0;
            num_nos_q  <= '0;
            erro_q     <= ERR_OK;
        end else begin
            state_q    <= state_d;
            fonte_q    <= fonte_d;
            current_q  <= current_d;
            pai_addr_q <= pai_addr_d;
            cnt_q      <= cnt_d;
            num_nos_q  <= num_nos_d;
            erro_q     <= erro_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        fonte_d    = fonte_q;
        current_d  = current_q;
        pai_addr_d = pai_addr_q;
        cnt_d      = cnt_q;
        num_nos_d  = num_nos_q;
        erro_d     = erro_q;
        cnt_inc    = cnt_q + 1'b1;
        is_last    = (current_q == fonte_q);

        case (state_q)
            IDLE: begin
                if (start_in) begin
                    cnt_d     = '0;
                    num_nos_d = '0;
                    if (encontrado_in) begin
                        fonte_d   = fonte_in;
                        current_d = destino_in;
                        erro_d    = ERR_OK;
                        state_d   = EMIT;
                    end else begin
                        erro_d  = ERR_NOT_FOUND;
                        state_d = FIM;
                    end
                end
            end
            EMIT: begin
                if (caminho_ready_in) begin
                    cnt_d = cnt_inc;
                    if (is_last) begin
                        state_d = FIM;
                    end else if (cnt_inc == MAX_CNT) begin
                        erro_d  = ERR_LENGTH;
                        state_d = FIM;
                    end else begin
                        pai_addr_d = current_q;
                        state_d    = READ;
                    end
                end
            end
            READ: state_d = WAIT;
            WAIT: begin
                // Only self-loops are caught here; longer cycles run into the length limit.
                if (pai_data_in == current_q) begin
                    erro_d  = ERR_LOOP;
                    state_d = FIM;
                end else begin
                    current_d = pai_data_in;
                    state_d   = EMIT;
                end
            end
            FIM: begin
                num_nos_d = cnt_q;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign pai_rd_en_out     = (state_q == READ);
    assign pai_addr_out      = pai_addr_q;
    assign caminho_valid_out = (state_q == EMIT);
    assign caminho_addr_out  = current_q;
    assign caminho_last_out  = (state_q == EMIT) && is_last;
    assign busy_out          = (state_q != IDLE);
    assign done_out          = (state_q == FIM);
    assign erro_out          = erro_q;
    assign num_nos_out       = num_nos_q;

endmodule

// File: tb/tb_reconstrutor_caminho.sv
// tb/tb_reconstrutor_caminho.sv - directed self-checking bench for reconstrutor_caminho
module tb_reconstrutor_caminho;

    logic       clk;
    logic       rst_n;
    logic       start_in;
    logic       encontrado_in;
    logic [9:0] fonte_in;
    logic [9:0] destino_in;
    logic       pai_rd_en_out;
    logic [9:0] pai_addr_out;
    logic [9:0] pai_data_in;
    logic       caminho_valid_out;
    logic       caminho_ready_in;
    logic [9:0] caminho_addr_out;
    logic       caminho_last_out;
    logic       busy_out;
    logic       done_out;
    logic [1:0] erro_out;
    logic [3:0] num_nos_out;

    int checks = 0;
    int passed = 0;

    logic [9:0] pai_mem [0:1023];
    logic [9:0] got [$];
    logic       got_last [$];
    int         hs [$];
    int         rd_seen;
    int         valid_seen;
    int         unstable;
    int         done_cyc;

    logic [9:0] exp_lin [4] = '{10'd31, 10'd30, 10'd22, 10'd0};

    reconstrutor_caminho #(
        .ADDR_WIDTH  (10),
        .MAX_PATH_LEN(8),
        .CNT_WIDTH   (4)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .start_in         (start_in),
        .encontrado_in    (encontrado_in),
        .fonte_in         (fonte_in),
        .destino_in       (destino_in),
        .pai_rd_en_out    (pai_rd_en_out),
        .pai_addr_out     (pai_addr_out),
        .pai_data_in      (pai_data_in),
        .caminho_valid_out(caminho_valid_out),
        .caminho_ready_in (caminho_ready_in),
        .caminho_addr_out (caminho_addr_out),
        .caminho_last_out (caminho_last_out),
        .busy_out         (busy_out),
        .done_out         (done_out),
        .erro_out         (erro_out),
        .num_nos_out      (num_nos_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Predecessor memory: one-cycle read latency.
    always @(posedge clk) begin
        if (pai_rd_en_out) pai_data_in <= pai_mem[pai_addr_out];
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_walk(input logic [9:0] f, input logic [9:0] d, input logic enc,
                            input bit bp, input int inj);
        logic       prev_stall;
        logic [9:0] prev_addr;
        logic       prev_last;
        got.delete();
        got_last.delete();
        hs.delete();
        rd_seen    = 0;
        valid_seen = 0;
        unstable   = 0;
        done_cyc   = -1;
        prev_stall = 1'b0;
        prev_addr  = '0;
        prev_last  = 1'b0;
        fonte_in      = f;
        destino_in    = d;
        encontrado_in = enc;
        start_in      = 1'b1;
        caminho_ready_in = 1'b0;
        step();
        start_in      = 1'b0;
        encontrado_in = 1'b0;
        for (int c = 1; c <= 200; c++) begin
            if (inj != 0 && c == inj) begin
                start_in      = 1'b1;
                encontrado_in = 1'b1;
                fonte_in      = 10'd9;
                destino_in    = 10'd9;
            end else begin
                start_in = 1'b0;
            end
            caminho_ready_in = bp ? (c % 2 == 0) : 1'b1;
            if (prev_stall && !(caminho_valid_out && caminho_addr_out == prev_addr
                                && caminho_last_out == prev_last))
                unstable++;
            if (pai_rd_en_out) rd_seen++;
            if (caminho_valid_out) valid_seen++;
            if (caminho_valid_out && caminho_ready_in) begin
                got.push_back(caminho_addr_out);
                got_last.push_back(caminho_last_out);
                hs.push_back(c);
            end
            prev_stall = caminho_valid_out && !caminho_ready_in;
            prev_addr  = caminho_addr_out;
            prev_last  = caminho_last_out;
            if (done_out) begin
                done_cyc = c;
                break;
            end
            step();
        end
        start_in = 1'b0;
        caminho_ready_in = 1'b0;
        step();
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        start_in = 1'b0;
        encontrado_in = 1'b0;
        fonte_in = '0;
        destino_in = '0;
        caminho_ready_in = 1'b0;
        for (int i = 0; i < 1024; i++) pai_mem[i] = '0;
        pai_mem[31] = 10'd30;
        pai_mem[30] = 10'd22;
        pai_mem[22] = 10'd0;
        pai_mem[7]  = 10'd7;
        pai_mem[3]  = 10'd4;
        pai_mem[4]  = 10'd3;
        step();
        step();
        checks++;
        if ({caminho_valid_out, caminho_last_out, busy_out, done_out, pai_rd_en_out} !== 5'b0) begin
            $display("FAIL reset_ctrl: got %b want 00000",
                     {caminho_valid_out, caminho_last_out, busy_out, done_out, pai_rd_en_out});
        end else passed++;
        checks++;
        if ({erro_out, num_nos_out, pai_addr_out, caminho_addr_out} !== 26'd0) begin
            $display("FAIL reset_data: erro %0d num %0d pai_addr %0d addr %0d want all 0",
                     erro_out, num_nos_out, pai_addr_out, caminho_addr_out);
        end else passed++;
        rst_n = 1'b0;
        step();
    endtask

    task automatic test_linear();
        run_walk(10'd0, 10'd31, 1'b1, 1'b0, 0);
        checks++;
        if (got.size() !== 4) $display("FAIL lin_count: got %0d want 4", got.size());
        else passed++;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (i >= got.size() || got[i] !== exp_lin[i] || got_last[i] !== (i == 3))
                $display("FAIL lin_node%0d: got %0d/last %0d want %0d/last %0d", i,
                         (i < got.size()) ? got[i] : 10'h3ff,
                         (i < got.size()) ? got_last[i] : 1'bx, exp_lin[i], (i == 3));
            else passed++;
            checks++;
            if (i >= hs.size() || hs[i] !== 1 + 3 * i)
                $display("FAIL lin_hs%0d: got cycle %0d want %0d", i,
                         (i < hs.size()) ? hs[i] : -1, 1 + 3 * i);
            else passed++;
        end
        checks++;
        if (done_cyc !== 11) $display("FAIL lin_done: got cycle %0d want 11", done_cyc);
        else passed++;
        checks++;
        if (erro_out !== 2'd0 || num_nos_out !== 4'd4 || busy_out !== 1'b0)
            $display("FAIL lin_status: erro %0d num %0d busy %0d want 0 4 0",
                     erro_out, num_nos_out, busy_out);
        else passed++;
    endtask

    task automatic test_backpressure();
        run_walk(10'd0, 10'd31, 1'b1, 1'b1, 0);
        checks++;
        if (got.size() !== 4) $display("FAIL bp_count: got %0d want 4", got.size());
        else passed++;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (i >= got.size() || got[i] !== exp_lin[i] || got_last[i] !== (i == 3))
                $display("FAIL bp_node%0d: got %0d want %0d", i,
                         (i < got.size()) ? got[i] : 10'h3ff, exp_lin[i]);
            else passed++;
        end
        checks++;
        if (unstable !== 0) $display("FAIL bp_stable: got %0d unstable cycles want 0", unstable);
        else passed++;
        checks++;
        if (done_cyc !== 15) $display("FAIL bp_done: got cycle %0d want 15", done_cyc);
        else passed++;
        checks++;
        if (erro_out !== 2'd0 || num_nos_out !== 4'd4)
            $display("FAIL bp_status: erro %0d num %0d want 0 4", erro_out, num_nos_out);
        else passed++;
    endtask

    task automatic test_not_found();
        run_walk(10'd0, 10'd31, 1'b0, 1'b0, 0);
        checks++;
        if (valid_seen !== 0 || rd_seen !== 0)
            $display("FAIL nf_stream: valid %0d reads %0d want 0 0", valid_seen, rd_seen);
        else passed++;
        checks++;
        if (done_cyc !== 1) $display("FAIL nf_done: got cycle %0d want 1", done_cyc);
        else passed++;
        checks++;
        if (erro_out !== 2'd1 || num_nos_out !== 4'd0)
            $display("FAIL nf_status: erro %0d num %0d want 1 0", erro_out, num_nos_out);
        else passed++;
    endtask

    task automatic test_single();
        run_walk(10'd5, 10'd5, 1'b1, 1'b0, 0);
        checks++;
        if (got.size() !== 1 || got[0] !== 10'd5 || got_last[0] !== 1'b1)
            $display("FAIL single_node: count %0d node %0d want 1 node 5 last 1",
                     got.size(), (got.size() > 0) ? got[0] : 10'h3ff);
        else passed++;
        checks++;
        if (rd_seen !== 0) $display("FAIL single_reads: got %0d want 0", rd_seen);
        else passed++;
        checks++;
        if (done_cyc !== 2 || erro_out !== 2'd0 || num_nos_out !== 4'd1)
            $display("FAIL single_status: done %0d erro %0d num %0d want 2 0 1",
                     done_cyc, erro_out, num_nos_out);
        else passed++;
    endtask

    task automatic test_loop();
        run_walk(10'd0, 10'd7, 1'b1, 1'b0, 0);
        checks++;
        if (got.size() !== 1 || got[0] !== 10'd7 || got_last[0] !== 1'b0)
            $display("FAIL loop_node: count %0d want 1 node 7 last 0", got.size());
        else passed++;
        checks++;
        if (done_cyc !== 4 || erro_out !== 2'd2 || num_nos_out !== 4'd1)
            $display("FAIL loop_status: done %0d erro %0d num %0d want 4 2 1",
                     done_cyc, erro_out, num_nos_out);
        else passed++;
    endtask

    task automatic test_length();
        run_walk(10'd0, 10'd3, 1'b1, 1'b0, 0);
        checks++;
        if (got.size() !== 8) $display("FAIL len_count: got %0d want 8", got.size());
        else passed++;
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (i >= got.size() || got[i] !== ((i % 2 == 0) ? 10'd3 : 10'd4) || got_last[i] !== 1'b0)
                $display("FAIL len_node%0d: got %0d want %0d", i,
                         (i < got.size()) ? got[i] : 10'h3ff, (i % 2 == 0) ? 3 : 4);
            else passed++;
        end
        checks++;
        if (done_cyc !== 23 || erro_out !== 2'd3 || num_nos_out !== 4'd8)
            $display("FAIL len_status: done %0d erro %0d num %0d want 23 3 8",
                     done_cyc, erro_out, num_nos_out);
        else passed++;
    endtask

    task automatic test_busy_start();
        run_walk(10'd0, 10'd31, 1'b1, 1'b0, 5);
        checks++;
        if (got.size() !== 4) $display("FAIL busy_count: got %0d want 4", got.size());
        else passed++;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (i >= got.size() || got[i] !== exp_lin[i] || got_last[i] !== (i == 3))
                $display("FAIL busy_node%0d: got %0d want %0d", i,
                         (i < got.size()) ? got[i] : 10'h3ff, exp_lin[i]);
            else passed++;
        end
        checks++;
        if (done_cyc !== 11 || erro_out !== 2'd0 || num_nos_out !== 4'd4)
            $display("FAIL busy_status: done %0d erro %0d num %0d want 11 0 4",
                     done_cyc, erro_out, num_nos_out);
        else passed++;
    endtask

    task automatic test_reset_mid();
        fonte_in = 10'd0;
        destino_in = 10'd31;
        encontrado_in = 1'b1;
        start_in = 1'b1;
        caminho_ready_in = 1'b1;
        step();
        start_in = 1'b0;
        encontrado_in = 1'b0;
        step();
        step();
        checks++;
        if (busy_out !== 1'b1 || pai_addr_out !== 10'd31)
            $display("FAIL rst_mid_pre: busy %0d pai_addr %0d want 1 31", busy_out, pai_addr_out);
        else passed++;
        rst_n = 1'b1;
        #1;
        checks++;
        if ({caminho_valid_out, caminho_last_out, busy_out, done_out, pai_rd_en_out} !== 5'b0
            || pai_addr_out !== 10'd0 || caminho_addr_out !== 10'd0)
            $display("FAIL rst_mid_async: ctrl %b pai_addr %0d addr %0d want 0 0 0",
                     {caminho_valid_out, caminho_last_out, busy_out, done_out, pai_rd_en_out},
                     pai_addr_out, caminho_addr_out);
        else passed++;
        step();
        checks++;
        if (done_out !== 1'b0 || caminho_valid_out !== 1'b0)
            $display("FAIL rst_mid_hold: done %0d valid %0d want 0 0", done_out, caminho_valid_out);
        else passed++;
        rst_n = 1'b0;
        step();
        run_walk(10'd5, 10'd5, 1'b1, 1'b0, 0);
        checks++;
        if (got.size() !== 1 || got[0] !== 10'd5 || erro_out !== 2'd0 || num_nos_out !== 4'd1)
            $display("FAIL rst_mid_after: count %0d erro %0d num %0d want 1 0 1",
                     got.size(), erro_out, num_nos_out);
        else passed++;
    endtask

    initial begin
        test_reset();
        test_linear();
        test_backpressure();
        test_not_found();
        test_single();
        test_loop();
        test_length();
        test_busy_start();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
